// File: rtl/joy_db9_scanner.sv
// joy_db9_scanner: drives the DB9 splitter shift register (joyLd/joyCk),
// shifts in 16 active-low button bits per frame, requires DEB identical
// frames in a row, then presents two active-high joystick words.
// Button order inside each word: [7] start [6] fire3 [5] fire2 [4] fire1
// [3] up [2] down [1] left [0] right.
module joy_db9_scanner #(
    parameter int DIV = 25,   // ce-cycles per half period of joyCk
    parameter int DEB = 2     // identical frames needed before a commit
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ce,
    input  logic       joyD,
    output logic       joyCk,
    output logic       joyLd,
    output logic [7:0] joy1,
    output logic [7:0] joy2,
    output logic       valid
);

    typedef enum logic [1:0] {
        S_LOAD,
        S_LOW,
        S_HIGH,
        S_COMMIT
    } state_t;

    localparam logic [7:0] PC_LAST = 8'(DIV - 1);
    localparam logic [4:0] BC_LAST = 5'd15;
    localparam logic [3:0] MC_MAX  = 4'd15;
    localparam logic [3:0] DEB_MIN = 4'(DEB);

    // Reject parameter values the counters cannot represent.
    generate
        if (DIV < 4 || DIV > 255) begin : g_bad_div
            $fatal(1, "joy_db9_scanner: DIV must be in 4..255");
        end
        if (DEB < 1 || DEB > 15) begin : g_bad_deb
            $fatal(1, "joy_db9_scanner: DEB must be in 1..15");
        end
    endgenerate

    // Synchroniser for the asynchronous serial input
    logic [1:0] joyd_pipe;
    logic       joyD_s;

    // Sequencer
    state_t     state;
    state_t     state_nxt;
    logic [7:0] pc;
    logic [4:0] bc;
    logic       phase_end;

    // Per-state controls decoded from the current state
    logic       ck_lvl;
    logic       ld_lvl;
    logic       sample_en;
    logic       bc_clr;
    logic       bc_inc;
    logic       commit_en;

    // Frame capture and debounce
    logic [15:0]     sh;
    logic [15:0]     prev;
    logic [3:0]      mc;
    logic [3:0]      mc_inc;
    logic [3:0]      mc_new;
    logic            commit_hit;
    logic [1:0][7:0] joy_q;

    assign joyD_s    = joyd_pipe[1];
    assign phase_end = (pc == PC_LAST);

    // Two-flop synchroniser, clocked every cycle so ce does not widen its latency
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            joyd_pipe <= 2'b11;
        end else begin
            joyd_pipe <= {joyd_pipe[0], joyD};
        end
    end

    // State register, advances only on ce
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_LOAD;
        end else if (ce) begin
            state <= state_nxt;
        end
    end

    // Next-state: each phase lasts DIV ce-cycles, COMMIT lasts one
    always_comb begin
        state_nxt = state;
        case (state)
            S_LOAD:   if (phase_end) state_nxt = S_LOW;
            S_LOW:    if (phase_end) state_nxt = S_HIGH;
            S_HIGH:   if (phase_end) state_nxt = (bc == BC_LAST) ? S_COMMIT : S_LOW;
            S_COMMIT: state_nxt = S_LOAD;
            default:  state_nxt = S_LOAD;
        endcase
    end

    // Output decode: splitter line levels and datapath strobes per state
    always_comb begin
        ck_lvl    = 1'b0;
        ld_lvl    = 1'b1;
        sample_en = 1'b0;
        bc_clr    = 1'b0;
        bc_inc    = 1'b0;
        commit_en = 1'b0;
        case (state)
            S_LOAD: begin
                ld_lvl = 1'b0;
                bc_clr = phase_end;
            end
            S_LOW: begin
                sample_en = phase_end;
            end
            S_HIGH: begin
                ck_lvl = 1'b1;
                bc_inc = phase_end && (bc != BC_LAST);
            end
            S_COMMIT: begin
                commit_en = 1'b1;
            end
            default: ;
        endcase
    end

    // Splitter lines are registered, so each edge lags its state by one
    // ce-cycle; this puts the sample point DIV-1 ce-cycles after a joyCk fall.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            joyCk <= 1'b0;
            joyLd <= 1'b1;
        end else if (ce) begin
            joyCk <= ck_lvl;
            joyLd <= ld_lvl;
        end
    end

    // Phase and bit counters; pc reloads instead of wrapping
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc <= '0;
            bc <= '0;
        end else if (ce) begin
            if (phase_end || commit_en) begin
                pc <= '0;
            end else begin
                pc <= pc + 8'd1;
            end
            if (bc_clr) begin
                bc <= '0;
            end else if (bc_inc) begin
                bc <= bc + 5'd1;
            end
        end
    end

    // Capture one inverted bit at the end of each LOW phase; first bit lands in sh[15]
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sh <= '0;
        end else if (ce && sample_en) begin
            sh[~bc[3:0]] <= ~joyD_s;
        end
    end

    // Consecutive-match count saturates at 15; a differing frame restarts it at 1
    assign mc_inc     = (mc == MC_MAX) ? MC_MAX : mc + 4'd1;
    assign mc_new     = (sh == prev) ? mc_inc : 4'd1;
    assign commit_hit = (mc_new >= DEB_MIN);

    // Debounce and commit; valid is cleared every clock so it is one cycle wide
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev  <= '0;
            mc    <= '0;
            joy_q <= '0;
            valid <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (ce && commit_en) begin
                prev <= sh;
                mc   <= mc_new;
                if (commit_hit) begin
                    joy_q <= sh;
                    valid <= 1'b1;
                end
            end
        end
    end

    assign joy1 = joy_q[1];
    assign joy2 = joy_q[0];

endmodule

// File: tb/tb_joy_db9_scanner.sv
// Directed bench for joy_db9_scanner with a behavioural DB9 splitter model.
module tb_joy_db9_scanner;

    localparam int FRAME = 826;   // (2*16+1)*25+1 ce-cycles

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ce = 1'b0;
    logic       joyD;
    logic       joyCk;
    logic       joyLd;
    logic [7:0] joy1;
    logic [7:0] joy2;
    logic       valid;

    int total = 0;
    int bad = 0;

    // Splitter model: loads a pattern on joyLd falling, shifts on joyCk rising.
    // With alt set, consecutive frames alternate between pat_a and pat_b.
    logic [15:0] pat_a = 16'hFFFF;
    logic [15:0] pat_b = 16'hFFFF;
    logic [15:0] cur = 16'hFFFF;
    bit          alt = 1'b0;
    bit          sel = 1'b0;
    bit          glitch = 1'b0;
    int          idx = 0;

    joy_db9_scanner dut (
        .clock (clock),
        .reset (reset),
        .ce    (ce),
        .joyD  (joyD),
        .joyCk (joyCk),
        .joyLd (joyLd),
        .joy1  (joy1),
        .joy2  (joy2),
        .valid (valid)
    );

    always #5 clock = ~clock;

    always @(negedge joyLd) begin
        sel = alt ? ~sel : 1'b0;
        cur = sel ? pat_b : pat_a;
        idx = 0;
    end

    always @(posedge joyCk) begin
        if (idx < 15) idx = idx + 1;
    end

    assign joyD = cur[15 - idx] ^ glitch;

    task automatic do_reset();
        ce = 1'b0;
        glitch = 1'b0;
        alt = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        ce = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        total++; if (joyCk !== 1'b0) begin bad++; $display("FAIL reset_joyCk got=%b exp=0", joyCk); end
        total++; if (joyLd !== 1'b1) begin bad++; $display("FAIL reset_joyLd got=%b exp=1", joyLd); end
        total++; if (joy1 !== 8'h00) begin bad++; $display("FAIL reset_joy1 got=%h exp=00", joy1); end
        total++; if (joy2 !== 8'h00) begin bad++; $display("FAIL reset_joy2 got=%h exp=00", joy2); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid); end
        // No ce after release: nothing may start
        ce = 1'b0;
        reset = 1'b0;
        repeat (5) @(negedge clock);
        total++; if (joyLd !== 1'b1) begin bad++; $display("FAIL idle_no_ce_joyLd got=%b exp=1", joyLd); end
        ce = 1'b1;
        @(negedge clock);
        total++; if (joyLd !== 1'b0) begin bad++; $display("FAIL first_ce_joyLd got=%b exp=0", joyLd); end
    endtask

    task automatic test_idle();
        int ld_low, first_ld, pulses, hi_run, lo_run, bad_hi, bad_lo, nval, v1, v2;
        logic prev_ck;
        ld_low = 0; first_ld = 0; pulses = 0; hi_run = 0; lo_run = 0;
        bad_hi = 0; bad_lo = 0; nval = 0; v1 = 0; v2 = 0; prev_ck = 1'b0;
        pat_a = 16'hFFFF;
        do_reset();
        ce = 1'b1;
        for (int k = 1; k <= 3 * FRAME; k++) begin
            @(negedge clock);
            if (k <= FRAME) begin
                if (!joyLd) begin
                    ld_low++;
                    if (first_ld == 0) first_ld = k;
                end
                if (joyCk) begin
                    if (!prev_ck) begin
                        pulses++;
                        if (pulses > 1 && lo_run != 25) bad_lo++;
                        hi_run = 0;
                    end
                    hi_run++;
                end else begin
                    if (prev_ck) begin
                        if (hi_run != 25) bad_hi++;
                        lo_run = 0;
                    end
                    lo_run++;
                end
                prev_ck = joyCk;
            end
            if (valid) begin
                nval++;
                if (nval == 1) v1 = k;
                if (nval == 2) v2 = k;
            end
        end
        total++; if (first_ld !== 1) begin bad++; $display("FAIL idle_first_ld got=%0d exp=1", first_ld); end
        total++; if (ld_low !== 25) begin bad++; $display("FAIL idle_ld_low got=%0d exp=25", ld_low); end
        total++; if (pulses !== 16) begin bad++; $display("FAIL idle_ck_pulses got=%0d exp=16", pulses); end
        total++; if (bad_hi !== 0) begin bad++; $display("FAIL idle_ck_high_width got=%0d wrong exp=0", bad_hi); end
        total++; if (bad_lo !== 0) begin bad++; $display("FAIL idle_ck_low_width got=%0d wrong exp=0", bad_lo); end
        // Frame 1 from reset only reaches mc=1, so commits come at frames 2 and 3
        total++; if (nval !== 2) begin bad++; $display("FAIL idle_valid_count got=%0d exp=2", nval); end
        total++; if (v1 !== 2 * FRAME) begin bad++; $display("FAIL idle_valid1_cycle got=%0d exp=%0d", v1, 2 * FRAME); end
        total++; if (v2 !== 3 * FRAME) begin bad++; $display("FAIL idle_valid2_cycle got=%0d exp=%0d", v2, 3 * FRAME); end
        total++; if (joy1 !== 8'h00) begin bad++; $display("FAIL idle_joy1 got=%h exp=00", joy1); end
        total++; if (joy2 !== 8'h00) begin bad++; $display("FAIL idle_joy2 got=%h exp=00", joy2); end
    endtask

    task automatic test_mapping();
        int vk, early;
        vk = 0; early = 0;
        pat_a = 16'h7FFE;
        do_reset();
        ce = 1'b1;
        for (int k = 1; k <= 2 * FRAME + 10; k++) begin
            @(negedge clock);
            if (valid) begin vk = k; break; end
            if (joy1 !== 8'h00 || joy2 !== 8'h00) early++;
        end
        total++; if (vk !== 2 * FRAME) begin bad++; $display("FAIL map_valid_cycle got=%0d exp=%0d", vk, 2 * FRAME); end
        total++; if (early !== 0) begin bad++; $display("FAIL map_early_update got=%0d exp=0", early); end
        total++; if (joy1 !== 8'h80) begin bad++; $display("FAIL map_joy1 got=%h exp=80", joy1); end
        total++; if (joy2 !== 8'h01) begin bad++; $display("FAIL map_joy2 got=%h exp=01", joy2); end
        @(negedge clock);
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL map_valid_width got=%b exp=0", valid); end
        total++; if (joy1 !== 8'h80) begin bad++; $display("FAIL map_hold_joy1 got=%h exp=80", joy1); end
    endtask

    // Runs straight after test_mapping: pattern A = 7FFE is committed and frame 3 is loading A
    task automatic test_debounce();
        int found, vcnt, hold_bad, vk;
        found = 0; vcnt = 0; hold_bad = 0; vk = 0;
        pat_b = 16'h5AA5;
        alt = 1'b1;
        for (int k = 1; k <= FRAME + 10; k++) begin
            @(negedge clock);
            if (valid) begin found = 1; break; end
        end
        total++; if (found !== 1) begin bad++; $display("FAIL deb_repeat_commit got=%0d exp=1", found); end
        // Frames now alternate B, A, B, A: none may commit
        for (int k = 1; k <= 4 * FRAME; k++) begin
            @(negedge clock);
            if (valid) vcnt++;
            if (joy1 !== 8'h80 || joy2 !== 8'h01) hold_bad++;
        end
        total++; if (vcnt !== 0) begin bad++; $display("FAIL deb_alt_valid got=%0d exp=0", vcnt); end
        total++; if (hold_bad !== 0) begin bad++; $display("FAIL deb_alt_hold got=%0d exp=0", hold_bad); end
        // Hold C = EFF7: fire1 on player 1, up on player 2, commit after 2nd frame
        alt = 1'b0;
        pat_a = 16'hEFF7;
        for (int k = 1; k <= 2 * FRAME + 10; k++) begin
            @(negedge clock);
            if (valid) begin vk = k; break; end
        end
        total++; if (vk !== 2 * FRAME) begin bad++; $display("FAIL deb_hold_cycle got=%0d exp=%0d", vk, 2 * FRAME); end
        total++; if (joy1 !== 8'h10) begin bad++; $display("FAIL deb_joy1 got=%h exp=10", joy1); end
        total++; if (joy2 !== 8'h08) begin bad++; $display("FAIL deb_joy2 got=%h exp=08", joy2); end
    endtask

    task automatic test_ce_gating();
        int k, vk;
        k = 0; vk = 0;
        pat_a = 16'h7FFE;
        do_reset();
        // ce-edge n lands on clock edge 4(n-1)+1; the 2nd frame commits on ce-edge 1652
        while (k < 8 * FRAME + 40) begin
            ce = (k % 4 == 0);
            @(negedge clock);
            k++;
            if (valid) begin vk = k; break; end
        end
        total++; if (vk !== 4 * (2 * FRAME - 1) + 1) begin bad++; $display("FAIL ce_valid_cycle got=%0d exp=%0d", vk, 4 * (2 * FRAME - 1) + 1); end
        total++; if (joy1 !== 8'h80) begin bad++; $display("FAIL ce_joy1 got=%h exp=80", joy1); end
        total++; if (joy2 !== 8'h01) begin bad++; $display("FAIL ce_joy2 got=%h exp=01", joy2); end
        ce = (k % 4 == 0);
        @(negedge clock);
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL ce_valid_width got=%b exp=0", valid); end
        ce = 1'b0;
    endtask

    task automatic test_reset_mid();
        int ld_low, first_ld, vk;
        ld_low = 0; first_ld = 0; vk = 0;
        pat_a = 16'h7FFE;
        do_reset();
        ce = 1'b1;
        // Frame 3 starts after cycle 1652; cycle 2165 sits in the HIGH phase of bit 9
        repeat (2165) @(negedge clock);
        total++; if (joyCk !== 1'b1) begin bad++; $display("FAIL mid_pre_joyCk got=%b exp=1", joyCk); end
        total++; if (joy1 !== 8'h80) begin bad++; $display("FAIL mid_pre_joy1 got=%h exp=80", joy1); end
        reset = 1'b1;
        #1;
        total++; if (joyCk !== 1'b0) begin bad++; $display("FAIL mid_joyCk got=%b exp=0", joyCk); end
        total++; if (joyLd !== 1'b1) begin bad++; $display("FAIL mid_joyLd got=%b exp=1", joyLd); end
        total++; if (joy1 !== 8'h00) begin bad++; $display("FAIL mid_joy1 got=%h exp=00", joy1); end
        total++; if (joy2 !== 8'h00) begin bad++; $display("FAIL mid_joy2 got=%h exp=00", joy2); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b exp=0", valid); end
        repeat (3) @(negedge clock);
        reset = 1'b0;
        for (int k = 1; k <= 2 * FRAME + 10; k++) begin
            @(negedge clock);
            if (k <= FRAME && !joyLd) begin
                ld_low++;
                if (first_ld == 0) first_ld = k;
            end
            if (valid) begin vk = k; break; end
        end
        total++; if (first_ld !== 1) begin bad++; $display("FAIL mid_first_ld got=%0d exp=1", first_ld); end
        total++; if (ld_low !== 25) begin bad++; $display("FAIL mid_ld_low got=%0d exp=25", ld_low); end
        total++; if (vk !== 2 * FRAME) begin bad++; $display("FAIL mid_valid_cycle got=%0d exp=%0d", vk, 2 * FRAME); end
    endtask

    task automatic test_glitch();
        int k, vk;
        k = 0; vk = 0;
        pat_a = 16'hEFF7;
        do_reset();
        ce = 1'b1;
        // One-cycle inversions every 50 cycles, well clear of the sample edges
        while (k < 2 * FRAME + 10) begin
            glitch = (k % 50 == 10);
            @(negedge clock);
            k++;
            if (valid) begin vk = k; break; end
        end
        glitch = 1'b0;
        total++; if (vk !== 2 * FRAME) begin bad++; $display("FAIL glitch_valid_cycle got=%0d exp=%0d", vk, 2 * FRAME); end
        total++; if (joy1 !== 8'h10) begin bad++; $display("FAIL glitch_joy1 got=%h exp=10", joy1); end
        total++; if (joy2 !== 8'h08) begin bad++; $display("FAIL glitch_joy2 got=%h exp=08", joy2); end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_mapping();
        test_debounce();
        test_ce_gating();
        test_reset_mid();
        test_glitch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
